// File: rtl/pipe_tree_accum.sv
// pipe_tree_accum
//   Pipelined adder tree that reduces N_IN signed lanes per beat to one sum.
//   A two-state FSM behind the tree accumulates those sums over a packet and
//   reports one result per packet.
//
// States:
//   state   | meaning
//   S_IDLE  | no packet open; the next tree beat starts a new packet
//   S_ACCUM | packet open; tree beats add into acc until one carries last
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data carries a beat this cycle
//   in_last    beat closes its packet (qualified by in_valid)
//   in_data    N_IN packed two's-complement lanes, lane k at [k*IN_W +: IN_W]
//   out_valid  one-cycle pulse per packet result
//   out_sum    signed packet total, wraps modulo 2^ACC_W on overflow
//   out_ovf    packet had more than MAX_BEATS beats
//   out_beats  beat count of the packet, saturating at MAX_BEATS+1
module pipe_tree_accum #(
  parameter  int N_IN      = 8,
  parameter  int IN_W      = 8,
  parameter  int MAX_BEATS = 4,
  localparam int LEVELS    = $clog2(N_IN),
  localparam int TREE_W    = IN_W + LEVELS,
  localparam int ACC_W     = TREE_W + $clog2(MAX_BEATS),
  localparam int CNT_W     = $clog2(MAX_BEATS) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       out_beats
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  // Level 0 is the unregistered input lanes; level j holds N_IN>>j registered
  // sums, each one bit wider than its operands so no level can overflow.
  for (genvar j = 0; j <= LEVELS; j++) begin : g_lvl
    localparam int W   = IN_W + j;
    localparam int CNT = N_IN >> j;

    logic signed [W-1:0] sum [CNT];
    logic                vld;
    logic                lst;

    if (j == 0) begin : g_in
      for (genvar k = 0; k < N_IN; k++) begin : g_lane
        assign sum[k] = in_data[k*IN_W +: IN_W];
      end
      assign vld = in_valid;
      assign lst = in_last;
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) begin
          vld <= 1'b0;
          lst <= 1'b0;
        end else begin
          vld <= g_lvl[j-1].vld;
          lst <= g_lvl[j-1].lst;
          // operand gating: sums only move when a beat is present
          if (g_lvl[j-1].vld) begin
            for (int k = 0; k < CNT; k++) begin
              sum[k] <= W'(g_lvl[j-1].sum[2*k]) + W'(g_lvl[j-1].sum[2*k+1]);
            end
          end
        end
      end
    end
  end

  logic signed [TREE_W-1:0] tree_sum;
  logic signed [ACC_W-1:0]  tree_ext;
  logic                     tree_valid;
  logic                     tree_last;

  assign tree_sum   = g_lvl[LEVELS].sum[0];
  assign tree_valid = g_lvl[LEVELS].vld;
  assign tree_last  = g_lvl[LEVELS].lst;
  assign tree_ext   = ACC_W'(tree_sum);

  state_t                  state, state_d;
  logic signed [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0]        beat_cnt, cnt_d;
  logic                    emit;
  logic                    ovf_d;

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = beat_cnt;
    emit    = 1'b0;
    if (tree_valid) begin
      case (state)
        S_IDLE: begin
          acc_d = tree_ext;
          cnt_d = CNT_ONE;
          if (tree_last) begin
            emit = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
        S_ACCUM: begin
          // acc wraps naturally; the count sticks at MAX_BEATS+1
          acc_d = acc + tree_ext;
          cnt_d = (beat_cnt == CNT_SAT) ? beat_cnt : beat_cnt + CNT_ONE;
          if (tree_last) begin
            emit    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    ovf_d = (cnt_d > CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      beat_cnt  <= cnt_d;
      out_valid <= emit;
      if (emit) begin
        out_sum   <= acc_d;
        out_beats <= cnt_d;
        out_ovf   <= ovf_d;
      end
    end
  end

endmodule
